// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// the default bubble word and the fetch control state encoding.
package fetch_stage_pkg;

   localparam logic [5:0] OP_ALU     = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ADD_IMM = 6'h08;
   localparam logic [5:0] OP_LW      = 6'h23;

   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   // Sequential successor address; wraps modulo 2^32.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: hold freezes the contents, flush loads a bubble,
// otherwise the fetched word and its PC+4 are captured as a valid instruction.
module fetch_stage_ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] ir_d,
   input  logic [31:0] pc4_d,
   output logic [31:0] ir,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ir    <= NOP_INSTR;
         pc4   <= 32'd0;
         valid <= 1'b0;
      end else if (hold) begin
         ir    <= ir;
         pc4   <= pc4;
         valid <= valid;
      end else if (flush) begin
         ir    <= NOP_INSTR;
         pc4   <= 32'd0;
         valid <= 1'b0;
      end else begin
         ir    <= ir_d;
         pc4   <= pc4_d;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with stall/redirect/wait handling,
// IF/ID register, decode-field taps and a saturating stall-cycle counter.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic [31:0] ifid_ir,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic [5:0]  ifid_op,
   output logic [4:0]  ifid_rs,
   output logic [4:0]  ifid_rt,
   output logic [15:0] stall_count
);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic [31:0]  pc_plus4;
   logic         ifid_hold, ifid_flush;

   assign pc_plus4  = pc_inc(pc_reg);
   assign imem_addr = pc_reg;

   // Stall outranks redirect, so a branch resolved under stall is simply
   // re-presented by ID once the interlock releases.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      ifid_hold  = 1'b0;
      ifid_flush = 1'b0;

      case (state_reg)
         HOLD:    state_next = stall ? HOLD : (redirect ? FLUSH : RUN);
         FLUSH:   state_next = stall ? HOLD : (redirect ? FLUSH : RUN);
         default: state_next = stall ? HOLD : (redirect ? FLUSH : RUN);
      endcase

      if (stall) begin
         ifid_hold = 1'b1;
      end else if (redirect) begin
         pc_next    = redirect_pc;
         ifid_flush = 1'b1;
      end else if (!imem_valid) begin
         ifid_flush = 1'b1;
      end else begin
         pc_next = pc_plus4;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg <= RUN;
         pc_reg    <= RESET_PC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stall_count <= 16'd0;
      end else if (stall && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

   fetch_stage_ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clock  (clock),
      .resetn (resetn),
      .hold   (ifid_hold),
      .flush  (ifid_flush),
      .ir_d   (imem_rdata),
      .pc4_d  (pc_plus4),
      .ir     (ifid_ir),
      .pc4    (ifid_pc4),
      .valid  (ifid_valid)
   );

   assign ifid_op = ifid_ir[31:26];
   assign ifid_rs = ifid_ir[25:21];
   assign ifid_rt = ifid_ir[20:16];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table through a scoreboard queue,
// then hand sequences for counter saturation and asynchronous reset.
module tb_fetch_stage;

   localparam logic [31:0] TB_NOP = 32'h0000_0020;

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic        iv;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [31:0] ir;
      logic [31:0] pc4;
      logic        valid;
      logic [15:0] cnt;
   } vec_t;

   logic        clock = 1'b0;
   logic        resetn;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [31:0] ifid_ir;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic [5:0]  ifid_op;
   logic [4:0]  ifid_rs;
   logic [4:0]  ifid_rt;
   logic [15:0] stall_count;

   int checks = 0;
   int errors = 0;
   vec_t tbl[19];
   vec_t sb_q[$];

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (TB_NOP)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .ifid_ir     (ifid_ir),
      .ifid_pc4    (ifid_pc4),
      .ifid_valid  (ifid_valid),
      .ifid_op     (ifid_op),
      .ifid_rs     (ifid_rs),
      .ifid_rt     (ifid_rt),
      .stall_count (stall_count)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Instruction memory image: distinct op/rs/rt fields per word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:2] ^ 6'h23, a[6:2] ^ 5'h0A, a[8:4] ^ 5'h11, a[15:0]};
   endfunction

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                               input logic iv, input logic [31:0] rdata,
                               input logic [31:0] ea, input logic [31:0] eir,
                               input logic [31:0] epc4, input logic ev,
                               input logic [15:0] ec);
      vec_t v;
      v.stall = s;   v.redirect = r; v.rpc = rpc;  v.iv = iv;   v.rdata = rdata;
      v.addr  = ea;  v.ir = eir;     v.pc4 = epc4; v.valid = ev; v.cnt = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input vec_t e);
      chk("imem_addr", imem_addr, e.addr);
      chk("ifid_ir", ifid_ir, e.ir);
      chk("ifid_pc4", ifid_pc4, e.pc4);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
      chk("ifid_op", {26'd0, ifid_op}, {26'd0, e.ir[31:26]});
      chk("ifid_rs", {27'd0, ifid_rs}, {27'd0, e.ir[25:21]});
      chk("ifid_rt", {27'd0, ifid_rt}, {27'd0, e.ir[20:16]});
      chk("stall_count", {16'd0, stall_count}, {16'd0, e.cnt});
   endtask

   // Drives one cycle of inputs, queues the expectation, checks after the edge.
   task automatic step(input vec_t v, input string tag);
      vec_t e;
      stall       = v.stall;
      redirect    = v.redirect;
      redirect_pc = v.rpc;
      imem_valid  = v.iv;
      imem_rdata  = v.rdata;
      sb_q.push_back(v);
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      chk_all(e);
      $display("%s: st=%b rd=%b iv=%b -> addr=%h ir=%h pc4=%h v=%b cnt=%0d",
               tag, v.stall, v.redirect, v.iv, imem_addr, ifid_ir, ifid_pc4,
               ifid_valid, stall_count);
   endtask

   task automatic check_reset_values(input string tag, input logic [31:0] keep_rdata);
      vec_t e;
      e = mk(1'b0, 1'b0, 32'd0, 1'b0, keep_rdata, 32'd0, TB_NOP, 32'd0, 1'b0, 16'd0);
      chk_all(e);
      $display("%s: addr=%h ir=%h pc4=%h v=%b cnt=%0d",
               tag, imem_addr, ifid_ir, ifid_pc4, ifid_valid, stall_count);
   endtask

   initial begin
      vec_t e;
      resetn      = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      imem_valid  = 1'b0;
      imem_rdata  = 32'd0;

      tbl[0]  = mk(0, 0, 0, 1, mem_word(0), 32'd4, mem_word(0), 32'd4, 1, 0);
      tbl[1]  = mk(0, 0, 0, 1, mem_word(4), 32'd8, mem_word(4), 32'd8, 1, 0);
      tbl[2]  = mk(1, 0, 0, 1, mem_word(8), 32'd8, mem_word(4), 32'd8, 1, 1);
      tbl[3]  = mk(1, 0, 0, 1, mem_word(8), 32'd8, mem_word(4), 32'd8, 1, 2);
      tbl[4]  = mk(1, 0, 0, 1, mem_word(8), 32'd8, mem_word(4), 32'd8, 1, 3);
      tbl[5]  = mk(0, 0, 0, 1, mem_word(8), 32'd12, mem_word(8), 32'd12, 1, 3);
      tbl[6]  = mk(0, 0, 0, 1, mem_word(12), 32'd16, mem_word(12), 32'd16, 1, 3);
      tbl[7]  = mk(0, 1, 32'h100, 1, mem_word(16), 32'h100, TB_NOP, 32'd0, 0, 3);
      tbl[8]  = mk(0, 0, 0, 1, mem_word(32'h100), 32'h104, mem_word(32'h100), 32'h104, 1, 3);
      tbl[9]  = mk(1, 1, 32'h200, 1, mem_word(32'h104), 32'h104, mem_word(32'h100), 32'h104, 1, 4);
      tbl[10] = mk(0, 1, 32'h200, 1, mem_word(32'h104), 32'h200, TB_NOP, 32'd0, 0, 4);
      tbl[11] = mk(0, 0, 0, 1, mem_word(32'h200), 32'h204, mem_word(32'h200), 32'h204, 1, 4);
      tbl[12] = mk(0, 0, 0, 0, mem_word(32'h204), 32'h204, TB_NOP, 32'd0, 0, 4);
      tbl[13] = mk(0, 0, 0, 0, mem_word(32'h204), 32'h204, TB_NOP, 32'd0, 0, 4);
      tbl[14] = mk(0, 0, 0, 1, mem_word(32'h204), 32'h208, mem_word(32'h204), 32'h208, 1, 4);
      tbl[15] = mk(0, 1, 32'hFFFF_FFFC, 1, mem_word(32'h208), 32'hFFFF_FFFC, TB_NOP, 32'd0, 0, 4);
      tbl[16] = mk(0, 0, 0, 1, mem_word(32'hFFFF_FFFC), 32'd0, mem_word(32'hFFFF_FFFC), 32'd0, 1, 4);
      tbl[17] = mk(0, 1, 32'h40, 0, mem_word(0), 32'h40, TB_NOP, 32'd0, 0, 4);
      tbl[18] = mk(1, 0, 0, 0, mem_word(32'h40), 32'h40, TB_NOP, 32'd0, 0, 5);

      repeat (2) @(posedge clock);
      #1;
      check_reset_values("reset", 32'd0);
      resetn = 1'b1;

      for (int i = 0; i < 19; i++) begin
         step(tbl[i], $sformatf("vec %0d", i));
      end

      // Long stall: counter must pin at all-ones and stay there.
      stall      = 1'b1;
      imem_valid = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         @(posedge clock);
      end
      #1;
      chk("sat_count", {16'd0, stall_count}, 32'h0000_FFFF);
      chk("sat_addr", imem_addr, 32'h40);
      $display("saturate: cnt=%h addr=%h", stall_count, imem_addr);
      @(posedge clock);
      #1;
      chk("sat_nowrap", {16'd0, stall_count}, 32'h0000_FFFF);
      $display("saturate+1: cnt=%h", stall_count);

      // Asynchronous reset while stalled, checked before any clock edge.
      @(posedge clock);
      #2;
      resetn = 1'b0;
      #1;
      check_reset_values("async reset mid-stall (sat)", 32'd0);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      step(mk(0, 0, 0, 1, mem_word(0), 32'd4, mem_word(0), 32'd4, 1, 0), "post-reset fetch");
      for (int i = 1; i <= 5; i++) begin
         step(mk(1, 0, 0, 1, mem_word(4), 32'd4, mem_word(0), 32'd4, 1, 16'(i)),
              $sformatf("stall %0d", i));
      end
      #2;
      resetn = 1'b0;
      #1;
      check_reset_values("async reset mid-stall cnt5", mem_word(4));
      @(posedge clock);
      #1;
      resetn = 1'b1;
      step(mk(0, 0, 0, 1, mem_word(0), 32'd4, mem_word(0), 32'd4, 1, 0), "refetch after stall reset");

      // Reset in the cycle following a redirect discards the flush target.
      step(mk(0, 1, 32'h300, 1, mem_word(4), 32'h300, TB_NOP, 32'd0, 0, 0), "redirect 0x300");
      resetn = 1'b0;
      #1;
      check_reset_values("async reset mid-flush", mem_word(4));
      @(posedge clock);
      #1;
      resetn = 1'b1;
      step(mk(0, 0, 0, 1, mem_word(0), 32'd4, mem_word(0), 32'd4, 1, 0), "refetch after flush reset");

      e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (sb_q.size() != 0) begin
         chk("scoreboard_empty", sb_q.size(), e.addr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word written into IF/ID on bubble or flush.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hold request from the interlock unit; freezes PC and IF/ID.
REQ-006 redirect  input  1  taken branch or jump resolved in ID this cycle.
REQ-007 redirect_pc  input  32  target address for redirect.
REQ-008 imem_addr  output  32  instruction memory address; equals current PC.
REQ-009 imem_rdata  input  32  instruction word at imem_addr.
REQ-010 imem_valid  input  1  imem_rdata is valid this cycle; low means memory wait state.
REQ-011 ifid_ir  output  32  IF/ID instruction register.
REQ-012 ifid_pc4  output  32  IF/ID PC+4 of the held instruction.
REQ-013 ifid_valid  output  1  IF/ID holds a real instruction (not a bubble).
REQ-014 ifid_op  output  6  ifid_ir[31:26], fed to the interlock unit.
REQ-015 ifid_rs  output  5  ifid_ir[25:21].
REQ-016 ifid_rt  output  5  ifid_ir[20:16].
REQ-017 stall_count  output  16  saturating count of cycles with stall high.

Function
REQ-018 PC, PC+4 and redirect arithmetic SHALL be 32-bit unsigned modulo 2^32; PC 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 Per cycle, priority SHALL be: stall > redirect > imem wait > normal advance.
REQ-020 stall high: PC, ifid_ir, ifid_pc4, ifid_valid SHALL hold; redirect ignored that cycle (branch re-resolves when stall drops).
REQ-021 stall low, redirect high: PC <= redirect_pc; ifid_ir <= NOP_INSTR; ifid_valid <= 0; ifid_pc4 <= 0 (one-cycle flush of the wrong-path fetch).
REQ-022 stall low, redirect low, imem_valid low: PC holds; IF/ID loads bubble (NOP_INSTR, valid 0, pc4 0).
REQ-023 stall low, redirect low, imem_valid high: ifid_ir <= imem_rdata; ifid_pc4 <= PC+4; ifid_valid <= 1; PC <= PC+4.
REQ-024 imem_addr SHALL be combinationally equal to PC; fetch latency one cycle from PC to IF/ID.
REQ-025 ifid_op/rs/rt SHALL be combinational slices of ifid_ir.
REQ-026 stall_count SHALL increment by 1 each cycle stall is high, saturate at 16'hFFFF, never wrap.
REQ-027 State machine SHALL have states RUN (normal/wait), HOLD (stall asserted), FLUSH (cycle after redirect); RUN->HOLD on stall, HOLD->RUN when stall low, any->FLUSH on redirect with stall low, FLUSH->RUN/HOLD per next-cycle inputs; state is observable only through the outputs above.

Reset
REQ-028 While resetn low: PC = RESET_PC, ifid_ir = NOP_INSTR, ifid_pc4 = 0, ifid_valid = 0, stall_count = 0, state = RUN, asynchronously.
REQ-029 Reset asserted mid-stall or mid-flush SHALL discard the pending operation; first posedge after release fetches RESET_PC.

Structure
REQ-030 Shared package SHALL hold opcode constants (LW, BEQ, ADD_IMM, ALU, J, JAL), NOP_INSTR default, and the fetch state enum.
REQ-031 One sub-module, ifid_reg (IF/ID pipeline register with hold and flush controls), is natural; PC logic and counter stay in fetch_stage.

Verification
REQ-032 Reset release, imem_valid=1, sequential words -> imem_addr 0,4,8; ifid_pc4 4,8,12 one cycle behind; ifid_valid=1 from second posedge.
REQ-033 stall high 3 cycles at PC=8 -> PC stays 8, IF/ID unchanged, stall_count 0->3; advance resumes to 12 on release.
REQ-034 redirect=1, redirect_pc=32'h100 at PC=16 -> next imem_addr 32'h100, ifid_valid=0, ifid_ir=NOP_INSTR; then valid instruction with ifid_pc4=32'h104.
REQ-035 stall and redirect both high -> no redirect; redirect taken only on first cycle stall low.
REQ-036 imem_valid low 2 cycles -> PC holds, two bubbles (ifid_valid=0); PC=32'hFFFF_FFFC advances to 0; stall held 70000 cycles -> stall_count 16'hFFFF.
REQ-037 resetn pulsed low during stall with stall_count=5 -> outputs at reset values immediately, no clock edge required.
